aec_req_sched: RTL and testbench

- Shares one AEC expression-evaluator core between NREQ requesters using round-robin arbitration.
- Each granted requester streams its ASCII expression, terminated by '=' (8'd61), into a local buffer at its own pace.
- The scheduler then replays the whole expression to the core contiguously (one character per cycle, as the core requires).
- It waits for the core's valid/result and returns the result, or an error, to the owning requester.

---
 rtl/aec_req_sched.sv | 173 +++++++++++++++++
 tb/tb_aec_req_sched.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aec_req_sched.sv
// aec_req_sched: shares one AEC expression-evaluator core between NREQ
// requesters. A round-robin winner streams its '='-terminated expression into
// a local buffer at its own pace. The buffer is then replayed to the core one
// character per cycle with no gaps. The core's result, or an error, is
// returned to the owner.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   req_valid[NREQ]   requester i presents req_char[8i+7:8i]
//   req_char          packed ASCII characters, one byte per requester
//   req_ack[NREQ]     character of requester i consumed this cycle
//   resp_valid[NREQ]  one-cycle one-hot response strobe
//   resp_result[7]    result, held until the next response
//   resp_err          error flag qualifying resp_valid
//   core_ready        start strobe to the core (first character only)
//   core_ascii[8]     character to the core
//   core_valid        core result valid
//   core_result[7]    core result
//   busy              scheduler is not IDLE
module aec_req_sched #(
  parameter int NREQ    = 4,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_char,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   resp_valid,
  output logic [6:0]        resp_result,
  output logic              resp_err,
  output logic              core_ready,
  output logic [7:0]        core_ascii,
  input  logic              core_valid,
  input  logic [6:0]        core_result,
  output logic              busy
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = PW - 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, SEND, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   gnt, rr_ptr, pick, idx;
  logic            any_req;
  logic [PW-1:0]   wr_ptr, rd_ptr, len;
  logic [TW-1:0]   tmo;
  logic            err;
  logic [7:0]      mem [DEPTH];
  logic [7:0]      gnt_char;
  logic            gnt_vld, take, is_eq, tmo_hit;

  // Round-robin pick. Scanning offsets from high to low lets the nearest
  // requester at or after rr_ptr overwrite the others.
  always_comb begin
    pick    = rr_ptr;
    idx     = rr_ptr;
    any_req = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = GW'((int'(rr_ptr) + k) % NREQ);
      if (req_valid[idx]) begin
        pick    = idx;
        any_req = 1'b1;
      end
    end
  end

  // Select the granted requester's lane.
  always_comb begin
    gnt_char = 8'h00;
    gnt_vld  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (GW'(i) == gnt) begin
        gnt_char = req_char[i*8 +: 8];
        gnt_vld  = req_valid[i];
      end
    end
  end

  assign take  = ((state == LOAD) || (state == DRAIN)) && gnt_vld;
  assign is_eq = (gnt_char == 8'd61);
  // The counter is cleared on entry to WAIT. When this fires, the counter
  // reaches TIMEOUT-1 on the same edge that enters RESP. RESP therefore lands
  // TIMEOUT cycles after the cycle that presented '='.
  assign tmo_hit = (tmo == TW'(TIMEOUT - 2));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (any_req) state_nxt = LOAD;
      LOAD:  if (take) begin
               if (is_eq)                           state_nxt = (wr_ptr == '0) ? RESP : SEND;
               else if (wr_ptr == PW'(DEPTH - 1))   state_nxt = DRAIN;
             end
      DRAIN: if (take && is_eq) state_nxt = RESP;
      SEND:  if (rd_ptr == len - PW'(1)) state_nxt = WAIT;
      WAIT:  if (core_valid || tmo_hit) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ack    = take ? (NREQ'(1) << gnt) : '0;
  assign resp_valid = (state == RESP) ? (NREQ'(1) << gnt) : '0;
  assign resp_err   = (state == RESP) && err;
  assign core_ascii = (state == SEND) ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign core_ready = (state == SEND) && (rd_ptr == '0);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt         <= '0;
      rr_ptr      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      len         <= '0;
      tmo         <= '0;
      err         <= 1'b0;
      resp_result <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) gnt <= pick;
        LOAD: if (take) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (is_eq) begin
                  len    <= wr_ptr + PW'(1);
                  rd_ptr <= '0;
                  if (wr_ptr == '0) begin
                    err         <= 1'b1;
                    resp_result <= '0;
                  end
                end else if (wr_ptr == PW'(DEPTH - 1)) begin
                  err <= 1'b1;
                end
              end
        DRAIN: if (take && is_eq) resp_result <= '0;
        SEND: begin
                rd_ptr <= rd_ptr + PW'(1);
                tmo    <= '0;
              end
        WAIT: begin
                tmo <= tmo + TW'(1);
                if (core_valid) begin
                  resp_result <= core_result;
                  err         <= 1'b0;
                end else if (tmo_hit) begin
                  resp_result <= '0;
                  err         <= 1'b1;
                end
              end
        RESP: begin
                rr_ptr <= (gnt == GW'(NREQ - 1)) ? '0 : gnt + GW'(1);
                wr_ptr <= '0;
                err    <= 1'b0;
              end
        default: ;
      endcase
    end
  end

  // Expression buffer; contents need no reset.
  always_ff @(posedge clk) begin
    if ((state == LOAD) && gnt_vld) mem[wr_ptr[AW-1:0]] <= gnt_char;
  end
endmodule

// File: tb/tb_aec_req_sched.sv
// Bench for aec_req_sched. Requester drivers stream strings, and a core model
// answers after a programmable delay. A scoreboard of expected responses
// {owner, err, result} is filled when stimulus starts and is checked when
// resp_valid fires.
module tb_aec_req_sched;
  localparam int NREQ = 4, DEPTH = 16, TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_char;
  logic [NREQ-1:0]   req_ack, resp_valid;
  logic [6:0]        resp_result;
  logic              resp_err, core_ready, busy;
  logic [7:0]        core_ascii;
  logic              core_valid;
  logic [6:0]        core_result;

  always #5 clk = ~clk;

  aec_req_sched #(.NREQ(NREQ), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_char(req_char),
    .req_ack(req_ack), .resp_valid(resp_valid), .resp_result(resp_result),
    .resp_err(resp_err), .core_ready(core_ready), .core_ascii(core_ascii),
    .core_valid(core_valid), .core_result(core_result), .busy(busy)
  );

  typedef struct { int gnt; bit err; logic [6:0] res; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int cyc = 0;

  // requester driver state
  string       drv_s [NREQ];
  int          drv_p [NREQ];
  int          drv_c [NREQ];
  int          drv_reps [NREQ];
  int          drv_used [NREQ];
  bit          drv_act [NREQ];
  logic [31:0] drv_mask [NREQ];

  // monitor state
  int          ack_cnt [NREQ];
  int          bad_ack, ready_cnt, ready_pos, first_cyc, eq_cyc, span, resp_cyc;
  byte unsigned core_q[$];

  // core model knobs
  int          core_delay = 1;
  logic [6:0]  core_res = '0;
  bit          core_mute = 1'b0, core_from_char = 1'b0;
  int          core_cnt = 0;
  logic [6:0]  core_first = '0;

  exp_t        e_cur;
  logic [NREQ-1:0] exp_oh;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requester drivers: advance on an observed ack, hold valid low on masked cycles.
  initial begin
    req_valid = '0;
    req_char  = '0;
    for (int i = 0; i < NREQ; i++) begin
      drv_act[i] = 0; drv_p[i] = 0; drv_c[i] = 0; drv_used[i] = 0; drv_reps[i] = 0;
      drv_mask[i] = '0; drv_s[i] = "";
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (drv_act[i] && ack_cnt[i] != drv_used[i]) begin
          drv_used[i] = ack_cnt[i];
          if (drv_s[i][drv_p[i]] == "=") begin
            if (drv_reps[i] > 0) begin drv_reps[i]--; drv_p[i] = 0; end
            else drv_act[i] = 0;
          end else drv_p[i]++;
        end
        if (drv_act[i] && !drv_mask[i][drv_c[i][4:0]]) begin
          req_valid[i]       = 1'b1;
          req_char[i*8 +: 8] = drv_s[i][drv_p[i]];
        end else begin
          req_valid[i]       = 1'b0;
          req_char[i*8 +: 8] = 8'h00;
        end
        if (drv_act[i]) drv_c[i]++;
      end
    end
  end

  // Monitor, core model and scoreboard, all sampled on the falling edge.
  initial begin
    core_valid = 1'b0;
    core_result = '0;
    for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;
    forever begin
      @(negedge clk);
      core_valid = 1'b0;
      if (core_mute) core_cnt = 0;
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          core_valid  = 1'b1;
          core_result = core_from_char ? 7'(100 + int'(core_first) - 48) : core_res;
        end
      end
      for (int i = 0; i < NREQ; i++)
        if (req_ack[i]) begin
          ack_cnt[i]++;
          if (!req_valid[i]) bad_ack++;
        end
      if (core_ascii != 8'h00) begin
        if (core_ready) begin
          ready_cnt++;
          ready_pos  = core_q.size();
          first_cyc  = cyc;
          core_first = core_ascii[6:0];
        end
        core_q.push_back(core_ascii);
        if (core_ascii == 8'd61) begin
          eq_cyc = cyc;
          span   = cyc - first_cyc + 1;
          if (!core_mute) core_cnt = core_delay;
        end
      end
      if (resp_valid != '0) begin
        resp_cyc = cyc;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp resp_valid=%b", resp_valid);
        end else begin
          e_cur  = sb.pop_front();
          exp_oh = NREQ'(1) << e_cur.gnt;
          checks++;
          if (resp_valid !== exp_oh) begin
            errors++; $display("FAIL resp_owner got=%b exp=%b", resp_valid, exp_oh);
          end
          checks++;
          if (resp_err !== e_cur.err) begin
            errors++; $display("FAIL resp_err got=%b exp=%b", resp_err, e_cur.err);
          end
          checks++;
          if (resp_result !== e_cur.res) begin
            errors++; $display("FAIL resp_result got=%0d exp=%0d", resp_result, e_cur.res);
          end
        end
      end
    end
  end

  task automatic start_req(input int i, input string s, input int reps, input logic [31:0] mask);
    drv_s[i] = s; drv_p[i] = 0; drv_c[i] = 0; drv_reps[i] = reps; drv_mask[i] = mask;
    drv_used[i] = ack_cnt[i]; drv_act[i] = 1;
  endtask

  task automatic push_exp(input int g, input bit er, input logic [6:0] r);
    exp_t e;
    e.gnt = g; e.err = er; e.res = r;
    sb.push_back(e);
  endtask

  task automatic clear_mon();
    core_q.delete();
    bad_ack = 0; ready_cnt = 0; ready_pos = -1; span = 0; eq_cyc = -1; resp_cyc = -1;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    bit act;
    act = 1;
    while (n < budget && (act || sb.size() != 0 || busy)) begin
      @(negedge clk);
      n++;
      act = 0;
      for (int i = 0; i < NREQ; i++) act |= drv_act[i];
    end
    checks++;
    if (n >= budget) begin
      errors++; $display("FAIL %s_timeout got=%0d cycles exp<%0d", name, n, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (core_ready !== 1'b0)  begin errors++; $display("FAIL rst_core_ready got=%b exp=0", core_ready); end
    checks++; if (core_ascii !== 8'h00) begin errors++; $display("FAIL rst_core_ascii got=%h exp=00", core_ascii); end
    checks++; if (resp_valid !== '0)    begin errors++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_result !== '0)   begin errors++; $display("FAIL rst_resp_result got=%0d exp=0", resp_result); end
    checks++; if (resp_err !== 1'b0)    begin errors++; $display("FAIL rst_resp_err got=%b exp=0", resp_err); end
    checks++; if (req_ack !== '0)       begin errors++; $display("FAIL rst_req_ack got=%b exp=0", req_ack); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int a0 [NREQ];
    clear_mon();
    core_from_char = 1; core_delay = 2;
    for (int i = 0; i < NREQ; i++) a0[i] = ack_cnt[i];
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      start_req(i, $sformatf("%0d+%0d=", i, i), (i == 0) ? 1 : 0, '0);
      push_exp(i, 0, 7'(100 + i));
    end
    push_exp(0, 0, 7'd100);
    wait_done(2000, "round_robin");
    checks++;
    if (ack_cnt[0] - a0[0] != 8) begin errors++; $display("FAIL rr_acks0 got=%0d exp=8", ack_cnt[0] - a0[0]); end
    checks++;
    if (ack_cnt[3] - a0[3] != 4) begin errors++; $display("FAIL rr_acks3 got=%0d exp=4", ack_cnt[3] - a0[3]); end
  endtask

  task automatic test_single();
    string exp_s = "3+4*2=";
    bit ok;
    int a0;
    clear_mon();
    core_from_char = 0; core_res = 7'd11; core_delay = 5;
    a0 = ack_cnt[0];
    @(negedge clk);
    start_req(0, exp_s, 0, '0);
    push_exp(0, 0, 7'd11);
    wait_done(500, "single");
    ok = (core_q.size() == exp_s.len());
    for (int k = 0; k < exp_s.len() && ok; k++) if (core_q[k] !== exp_s[k]) ok = 0;
    checks++; if (!ok) begin errors++; $display("FAIL single_stream got_len=%0d exp=%s", core_q.size(), exp_s); end
    checks++; if (span != 6) begin errors++; $display("FAIL single_contig got=%0d exp=6", span); end
    checks++; if (ready_cnt != 1 || ready_pos != 0) begin
      errors++; $display("FAIL single_ready got=%0d@%0d exp=1@0", ready_cnt, ready_pos);
    end
    checks++; if (ack_cnt[0] - a0 != 6) begin errors++; $display("FAIL single_acks got=%0d exp=6", ack_cnt[0] - a0); end
  endtask

  task automatic test_overflow();
    int a0;
    clear_mon();
    a0 = ack_cnt[1];
    @(negedge clk);
    start_req(1, "12345678901234567890=", 0, '0);
    push_exp(1, 1, 7'd0);
    wait_done(500, "overflow");
    checks++; if (ack_cnt[1] - a0 != 21) begin errors++; $display("FAIL ovf_acks got=%0d exp=21", ack_cnt[1] - a0); end
    checks++; if (ready_cnt != 0 || core_q.size() != 0) begin
      errors++; $display("FAIL ovf_core_used got=%0d chars exp=0", core_q.size());
    end
  endtask

  task automatic test_gaps();
    string exp_s = "1+1=";
    bit ok;
    int a0;
    clear_mon();
    core_res = 7'd2; core_delay = 3;
    a0 = ack_cnt[2];
    @(negedge clk);
    start_req(2, exp_s, 0, 32'h54);
    push_exp(2, 0, 7'd2);
    wait_done(500, "gaps");
    checks++; if (bad_ack != 0) begin errors++; $display("FAIL gaps_ack_no_valid got=%0d exp=0", bad_ack); end
    checks++; if (ack_cnt[2] - a0 != 4) begin errors++; $display("FAIL gaps_acks got=%0d exp=4", ack_cnt[2] - a0); end
    ok = (core_q.size() == exp_s.len());
    for (int k = 0; k < exp_s.len() && ok; k++) if (core_q[k] !== exp_s[k]) ok = 0;
    checks++; if (!ok) begin errors++; $display("FAIL gaps_stream got_len=%0d exp=%s", core_q.size(), exp_s); end
    checks++; if (span != 4) begin errors++; $display("FAIL gaps_contig got=%0d exp=4", span); end
  endtask

  task automatic test_timeout();
    clear_mon();
    core_mute = 1;
    @(negedge clk);
    start_req(1, "7*7=", 0, '0);
    push_exp(1, 1, 7'd0);
    wait_done(1000, "timeout");
    checks++;
    if (resp_cyc - eq_cyc != TIMEOUT) begin
      errors++; $display("FAIL timeout_latency got=%0d exp=%0d", resp_cyc - eq_cyc, TIMEOUT);
    end
    core_mute = 0;
  endtask

  task automatic test_empty();
    int a0;
    clear_mon();
    a0 = ack_cnt[0];
    @(negedge clk);
    start_req(0, "=", 0, '0);
    push_exp(0, 1, 7'd0);
    wait_done(200, "empty");
    checks++; if (ready_cnt != 0 || core_q.size() != 0) begin
      errors++; $display("FAIL empty_core_used got=%0d chars exp=0", core_q.size());
    end
    checks++; if (ack_cnt[0] - a0 != 1) begin errors++; $display("FAIL empty_acks got=%0d exp=1", ack_cnt[0] - a0); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_mon();
    core_mute = 1;
    @(negedge clk);
    start_req(3, "9+9=", 0, '0);
    while (n < 200 && core_ascii == 8'h00) begin @(negedge clk); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL midrst_send_timeout got=%0d cycles exp<200", n); end
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) drv_act[i] = 0;
    #1;
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (core_ascii !== 8'h00) begin errors++; $display("FAIL midrst_core_ascii got=%h exp=00", core_ascii); end
    checks++; if (core_ready !== 1'b0)  begin errors++; $display("FAIL midrst_core_ready got=%b exp=0", core_ready); end
    checks++; if (req_ack !== '0 || resp_valid !== '0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL midrst_outs got=%b/%b/%b exp=0", req_ack, resp_valid, resp_err);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    core_mute = 0; core_from_char = 1; core_delay = 3;
    @(negedge clk);
    start_req(0, "5+5=", 0, '0);
    start_req(2, "6+6=", 0, '0);
    push_exp(0, 0, 7'd105);
    push_exp(2, 0, 7'd106);
    wait_done(1000, "post_reset");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mon();
    test_reset();
    test_round_robin();
    test_single();
    test_overflow();
    test_gaps();
    test_timeout();
    test_empty();
    test_reset_mid();
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL leftover_expected got=%0d exp=0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
